// File: rtl/apb_uart_tx_slave.sv
// apb_uart_tx_slave
//   APB completer with a byte TX FIFO and an 8N1 UART transmitter whose bit
//   period comes from a programmable divisor.
//
// Registers (offset = PADDR[3:0]):
//   0x0 TXDATA  W   push PWDATA[7:0] when PSTRB[0]=1; reads 0
//   0x4 STATUS  RO  [0] busy, [1] full, [2] empty, [12:8] count
//   0x8 BAUDDIV RW  [15:0], lanes 0/1 gated by PSTRB; bit = BAUDDIV+1 cycles
//   0xC CTRL    RW  [0] EN, [1] FLUSH (write-1 pulse, reads 0)
//
// Ports:
//   PCLK, PRESET                 clock, synchronous active-high reset
//   PSEL/PENABLE/PWRITE/PADDR/
//   PWDATA/PSTRB/PPROT           APB request (PPROT ignored)
//   PRDATA/PREADY/PSLVERR        APB response, all registered
//   TXD                          serial output, idles high
//   TX_IRQ                       level: EN & FIFO empty & transmitter idle
//   tx_state                     debug view of the TX FSM state
//
// Handshake: a transfer is requested while PSEL&PENABLE are high. The first
// such cycle always gets PREADY=0; the request is committed at the end of
// that cycle, so PREADY/PRDATA/PSLVERR show the result in the second cycle.
// PREADY drops again in the cycle after that.
module apb_uart_tx_slave #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_RESET = 16'd433
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [3:0]            PSTRB,
  input  logic [2:0]            PPROT,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  TXD,
  output logic                  TX_IRQ,
  output logic [1:0]            tx_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  tx_state_e state_q, state_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;

  logic [15:0] baud_div, bit_len, baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        en;

  logic        access, dec_err, wr_ok, rd_ok;
  logic [1:0]  reg_sel;
  logic        push_req, push, push_err, flush, load, bit_done, busy;
  logic [DATA_WIDTH-1:0] rdata_c;

  logic unused_ok;
  assign unused_ok = &{1'b0, PPROT, PSTRB[3:2], PWDATA[DATA_WIDTH-1:16]};

  // Commit happens in the wait-state cycle (PREADY still low).
  assign access   = PSEL & PENABLE & ~PREADY;
  assign reg_sel  = PADDR[3:2];
  assign dec_err  = (|PADDR[1:0]) | (|PADDR[ADDR_WIDTH-1:4]) | (PWRITE & (reg_sel == 2'd1));
  assign wr_ok    = access & PWRITE & ~dec_err;
  assign rd_ok    = access & ~PWRITE & ~dec_err;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  // Full is judged before any same-cycle pop, so a push at full is always dropped.
  assign push_req = wr_ok & (reg_sel == 2'd0) & PSTRB[0];
  assign push     = push_req & ~full;
  assign push_err = push_req & full;
  assign flush    = wr_ok & (reg_sel == 2'd3) & PSTRB[0] & PWDATA[1];

  assign bit_done = (baud_cnt == bit_len);
  assign busy     = (state_q != S_IDLE);
  assign tx_state = state_q;
  assign TX_IRQ   = en & empty & ~busy;

  always_comb begin
    case (state_q)
      S_START: TXD = 1'b0;
      S_DATA:  TXD = shreg[0];
      default: TXD = 1'b1;
    endcase
  end

  always_comb begin
    rdata_c = '0;
    case (reg_sel)
      2'd1: begin
        rdata_c[0]    = busy;
        rdata_c[1]    = full;
        rdata_c[2]    = empty;
        rdata_c[12:8] = 5'(count);
      end
      2'd2:    rdata_c[15:0] = baud_div;
      2'd3:    rdata_c[0]    = en;
      default: rdata_c = '0;
    endcase
  end

  // TX FSM next state; load pops the FIFO into the shifter.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && !empty) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: if (bit_done) state_d = S_DATA;
      S_DATA:  if (bit_done && bit_idx == 3'd7) state_d = S_STOP;
      S_STOP: begin
        if (bit_done) begin
          if (en && !empty) begin
            load    = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Bit timing and shifter. bit_len is latched at each pop so a BAUDDIV
  // change only affects the next frame.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      baud_cnt <= '0;
      bit_len  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else if (load) begin
      shreg    <= mem[rd_ptr];
      bit_len  <= baud_div;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (state_q != S_IDLE) begin
      if (bit_done) begin
        baud_cnt <= '0;
        if (state_q == S_DATA) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= PWDATA[7:0];
  end

  // FIFO pointers/count; flush overrides a same-cycle push or pop.
  always_ff @(posedge PCLK) begin
    if (PRESET || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (load) rd_ptr <= rd_ptr + PW'(1);
      case ({push, load})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      baud_div <= BAUD_RESET;
      en       <= 1'b0;
    end else if (wr_ok) begin
      if (reg_sel == 2'd2) begin
        if (PSTRB[0]) baud_div[7:0]  <= PWDATA[7:0];
        if (PSTRB[1]) baud_div[15:8] <= PWDATA[15:8];
      end
      if (reg_sel == 2'd3 && PSTRB[0]) en <= PWDATA[0];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else begin
      PREADY  <= access;
      PSLVERR <= access & (dec_err | push_err);
      PRDATA  <= rd_ok ? rdata_c : '0;
    end
  end

endmodule
